// File: rtl/jp_lift_fetch_if.sv
// jp_lift_fetch_if: sample-in, lift triplet/result and coefficient-out signals of jp_lift_fetch
//   slave  : the fetch block (accepts pix, issues triplets, takes results, emits coefs)
//   master : the surrounding environment driving the opposite directions
interface jp_lift_fetch_if;
  logic [15:0]  pix_i;
  logic         pix_valid_i;
  logic         pix_ready_o;
  logic [127:0] left_s_o;
  logic [127:0] sam_s_o;
  logic [127:0] right_s_o;
  logic [79:0]  flgs_s_o;
  logic         lift_valid_o;
  logic         lift_ready_i;
  logic [127:0] res_i;
  logic         res_valid_i;
  logic [15:0]  coef_o;
  logic         coef_valid_o;
  logic         coef_ready_i;
  modport slave (
    input  pix_i, pix_valid_i, lift_ready_i, res_i, res_valid_i, coef_ready_i,
    output pix_ready_o, left_s_o, sam_s_o, right_s_o, flgs_s_o, lift_valid_o, coef_o, coef_valid_o
  );
  modport master (
    output pix_i, pix_valid_i, lift_ready_i, res_i, res_valid_i, coef_ready_i,
    input  pix_ready_o, left_s_o, sam_s_o, right_s_o, flgs_s_o, lift_valid_o, coef_o, coef_valid_o
  );
endinterface

// File: rtl/jp_lift_fetch.sv
// jp_lift_fetch: row buffer feeding 8-lane 5/3 lifting triplets (predict, then update) and streaming lows then highs
//   clk_i/rst_i : clock, synchronous active-high reset
//   bus         : pix in, triplet groups out, lane results in, coefficients out
//   busy_o      : high whenever the block is not loading a row
module jp_lift_fetch #(
  parameter int ROW_LEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  jp_lift_fetch_if.slave   bus,
  output logic             busy_o
);
  localparam int N  = ROW_LEN;
  localparam int AW = $clog2(N);
  typedef enum logic [2:0] {LOAD, P_ISSUE, P_WAIT, U_ISSUE, U_WAIT, OUT} state_t;
  state_t state_q, state_d;
  logic [15:0]   x_q [N];
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] n [8];
  logic [AW-1:0] li [8];
  logic [AW-1:0] ri [8];
  logic [AW-1:0] oi;
  logic          pred, issue, wait_s, adv, wrap, last_g, last_n;
  // one counter serves as load index, group index and output index in turn
  assign pred   = state_q == P_ISSUE || state_q == P_WAIT;
  assign issue  = state_q == P_ISSUE || state_q == U_ISSUE;
  assign wait_s = state_q == P_WAIT || state_q == U_WAIT;
  assign last_g = cnt_q == AW'(N / 16 - 1);
  assign last_n = cnt_q == AW'(N - 1);
  assign adv    = (state_q == LOAD && bus.pix_valid_i) || (wait_s && bus.res_valid_i) ||
                  (state_q == OUT && bus.coef_ready_i);
  assign wrap   = wait_s ? last_g : last_n;
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LOAD;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (bus.pix_valid_i && last_n) state_d = P_ISSUE;
      P_ISSUE: if (bus.lift_ready_i) state_d = P_WAIT;
      P_WAIT:  if (bus.res_valid_i) state_d = last_g ? U_ISSUE : P_ISSUE;
      U_ISSUE: if (bus.lift_ready_i) state_d = U_WAIT;
      U_WAIT:  if (bus.res_valid_i) state_d = last_g ? OUT : U_ISSUE;
      OUT:     if (bus.coef_ready_i && last_n) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
    end else begin
      if (adv) cnt_q <= wrap ? '0 : cnt_q + AW'(1);
      if (state_q == LOAD && bus.pix_valid_i) x_q[cnt_q] <= bus.pix_i;
      if (wait_s && bus.res_valid_i)
        for (int k = 0; k < 8; k++) x_q[n[k]] <= bus.res_i[16*k +: 16];
    end
  end
  // lane centre n = 16g + 2k + pred; edges mirror inward (n=N-1 predict, n=0 update)
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      n[k]  = (cnt_q << 4) | AW'(2 * k) | AW'(pred);
      li[k] = n[k] == '0 ? AW'(1) : n[k] - AW'(1);
      ri[k] = n[k] == AW'(N - 1) ? AW'(N - 2) : n[k] + AW'(1);
    end
    oi = cnt_q < AW'(N / 2) ? cnt_q << 1 : ((cnt_q - AW'(N / 2)) << 1) | AW'(1);
  end
  always_comb begin
    bus.pix_ready_o  = state_q == LOAD;
    bus.lift_valid_o = issue;
    bus.coef_valid_o = state_q == OUT;
    bus.coef_o       = state_q == OUT ? x_q[oi] : '0;
    busy_o           = state_q != LOAD;
    bus.left_s_o     = '0;
    bus.sam_s_o      = '0;
    bus.right_s_o    = '0;
    bus.flgs_s_o     = '0;
    for (int k = 0; k < 8; k++) begin
      bus.left_s_o[16*k +: 16]  = issue ? x_q[li[k]] : '0;
      bus.sam_s_o[16*k +: 16]   = issue ? x_q[n[k]] : '0;
      bus.right_s_o[16*k +: 16] = issue ? x_q[ri[k]] : '0;
      bus.flgs_s_o[10*k +: 10]  = issue ? (pred ? 10'd7 : 10'd5) : '0;
    end
  end
endmodule

// File: tb/tb_jp_lift_fetch.sv
// tb_jp_lift_fetch: directed scoreboard bench for jp_lift_fetch
module tb_jp_lift_fetch;
  localparam int N = 32;
  typedef struct {
    logic [127:0] l;
    logic [127:0] s;
    logic [127:0] r;
    logic [79:0]  f;
  } grp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [15:0] m [N];
  grp_t gq[$];
  logic [15:0] cq[$];
  always #5 clk = ~clk;
  jp_lift_fetch_if bus();
  jp_lift_fetch #(.ROW_LEN(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave), .busy_o(busy));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic grp_t exp_grp(input bit pred, input int g);
    grp_t e;
    for (int k = 0; k < 8; k++) begin
      int c;
      c = 16 * g + 2 * k + (pred ? 1 : 0);
      e.s[16*k +: 16] = m[c];
      e.l[16*k +: 16] = (c == 0) ? m[1] : m[c-1];
      e.r[16*k +: 16] = (c == N - 1) ? m[N-2] : m[c+1];
      e.f[10*k +: 10] = pred ? 10'd7 : 10'd5;
    end
    return e;
  endfunction
  task automatic load_ramp();
    chk("load_ready", bus.pix_ready_o, 1);
    for (int i = 0; i < N; i++) begin
      bus.pix_i = 16'(i);
      bus.pix_valid_i = 1'b1;
      m[i] = 16'(i);
      tick();
    end
    bus.pix_valid_i = 1'b0;
    chk("lift_valid_after_load", bus.lift_valid_o, 1);
    chk("pix_ready_after_load", bus.pix_ready_o, 0);
  endtask
  task automatic issue_grp(input bit pred, input int g, input bit bp);
    grp_t e;
    int t;
    logic [127:0] hl, hs, hr;
    gq.push_back(exp_grp(pred, g));
    t = 0;
    while (!bus.lift_valid_o && t < 20) begin
      tick();
      t++;
    end
    chk("lift_valid_wait", bus.lift_valid_o, 1);
    e = gq.pop_front();
    chk("grp_left", bus.left_s_o, e.l);
    chk("grp_sam", bus.sam_s_o, e.s);
    chk("grp_right", bus.right_s_o, e.r);
    chk("grp_flags", bus.flgs_s_o, e.f);
    if (pred && g == 0) begin
      chk("p0_left0", bus.left_s_o[15:0], 0);
      chk("p0_right7", bus.right_s_o[127:112], 16);
    end
    if (pred && g == 1) begin
      chk("p1_right7_mirror", bus.right_s_o[127:112], 30);
      chk("p1_sam7", bus.sam_s_o[127:112], 31);
    end
    if (!pred && g == 0) begin
      chk("u0_left0_mirror", bus.left_s_o[15:0], 1001);
      chk("u0_sam0", bus.sam_s_o[15:0], 0);
      chk("u0_right0", bus.right_s_o[15:0], 1001);
      chk("u0_left1", bus.left_s_o[31:16], 1001);
      chk("u0_right1", bus.right_s_o[31:16], 1003);
    end
    if (bp) begin
      hl = bus.left_s_o;
      hs = bus.sam_s_o;
      hr = bus.right_s_o;
      bus.lift_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
        bus.res_valid_i = (i == 0);
        bus.res_i = {8{16'hDEAD}};
        tick();
        bus.res_valid_i = 1'b0;
        chk("bp_valid", bus.lift_valid_o, 1);
        chk("bp_left", bus.left_s_o, hl);
        chk("bp_sam", bus.sam_s_o, hs);
        chk("bp_right", bus.right_s_o, hr);
      end
    end
    bus.lift_ready_i = 1'b1;
    bus.res_valid_i = bp;
    bus.res_i = {8{16'hBEEF}};
    tick();
    bus.lift_ready_i = 1'b0;
    bus.res_valid_i = 1'b0;
    chk("wait_no_valid", bus.lift_valid_o, 0);
    chk("wait_busy", busy, 1);
  endtask
  task automatic return_res(input bit pred, input int g);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) begin
      int c;
      c = 16 * g + 2 * k + (pred ? 1 : 0);
      m[c] = 16'((pred ? 1000 : 2000) + c);
      r[16*k +: 16] = m[c];
    end
    bus.res_i = r;
    bus.res_valid_i = 1'b1;
    tick();
    bus.res_valid_i = 1'b0;
  endtask
  task automatic lift_passes(input bit bp);
    for (int g = 0; g < N / 16; g++) begin
      issue_grp(1'b1, g, bp && g == 0);
      return_res(1'b1, g);
    end
    for (int g = 0; g < N / 16; g++) begin
      issue_grp(1'b0, g, 1'b0);
      return_res(1'b0, g);
    end
  endtask
  task automatic out_phase();
    int t;
    bit stalled;
    logic [15:0] held, e;
    for (int i = 0; i < N / 2; i++) cq.push_back(m[2*i]);
    for (int i = 0; i < N / 2; i++) cq.push_back(m[2*i+1]);
    t = 0;
    stalled = 1'b0;
    held = '0;
    while (cq.size() > 0 && t < 200) begin
      bus.coef_ready_i = (t % 2) == 0;
      if (stalled) chk("coef_hold", bus.coef_o, held);
      if (bus.coef_valid_o && bus.coef_ready_i) begin
        e = cq.pop_front();
        chk("coef", bus.coef_o, e);
        stalled = 1'b0;
      end else if (bus.coef_valid_o) begin
        stalled = 1'b1;
        held = bus.coef_o;
      end
      tick();
      t++;
    end
    bus.coef_ready_i = 1'b0;
    chk("coef_all_seen", cq.size(), 0);
    chk("back_to_load_ready", bus.pix_ready_o, 1);
    chk("back_to_load_busy", busy, 0);
    chk("back_to_load_cvalid", bus.coef_valid_o, 0);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_pix_ready"}, bus.pix_ready_o, 1);
    chk({tag, "_lift_valid"}, bus.lift_valid_o, 0);
    chk({tag, "_left"}, bus.left_s_o, 0);
    chk({tag, "_sam"}, bus.sam_s_o, 0);
    chk({tag, "_right"}, bus.right_s_o, 0);
    chk({tag, "_flags"}, bus.flgs_s_o, 0);
    chk({tag, "_coef_valid"}, bus.coef_valid_o, 0);
    chk({tag, "_coef"}, bus.coef_o, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    bus.pix_i = '0;
    bus.pix_valid_i = 1'b0;
    bus.lift_ready_i = 1'b0;
    bus.res_i = '0;
    bus.res_valid_i = 1'b0;
    bus.coef_ready_i = 1'b0;
    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");
    load_ramp();
    lift_passes(1'b1);
    out_phase();
    load_ramp();
    for (int g = 0; g < N / 16; g++) begin
      issue_grp(1'b1, g, 1'b0);
      return_res(1'b1, g);
    end
    issue_grp(1'b0, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("abort");
    bus.res_i = {8{16'h5A5A}};
    bus.res_valid_i = 1'b1;
    tick();
    bus.res_valid_i = 1'b0;
    chk_idle("late_res");
    load_ramp();
    lift_passes(1'b0);
    out_phase();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jp_lift_fetch.md
Name: jp_lift_fetch

Overview:
- Upstream feeder for the jp_process lifting datapath (one-row, forward 5/3 DWT).
- Buffers one row of 16-bit samples, then issues 8-lane triplet groups (left_s/sam_s/right_s + flgs_s) for the predict pass and then the update pass.
- Writes each returned lane result back into the row buffer, then streams out the finished coefficients: lows, then highs.

Parameters:
- ROW_LEN, 32, samples per row; multiple of 16, ≥16 (N below).
- Fixed: lanes = 8, sample width = 16.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pix_i  in  16  input sample
- pix_valid_i  in  1  input sample valid
- pix_ready_o  out  1  block accepts a sample
- left_s_o  out  128  8 lanes × 16-bit left neighbour; lane k = bits[16k+15:16k]
- sam_s_o  out  128  8 lanes, centre sample
- right_s_o  out  128  8 lanes, right neighbour
- flgs_s_o  out  80  8 lanes × 10-bit flags; lane k = bits[10k+9:10k]
- lift_valid_o  out  1  triplet group valid
- lift_ready_i  in  1  jp_process accepts group
- res_i  in  128  8 lanes of lifted results for the outstanding group
- res_valid_i  in  1  res_i valid
- coef_o  out  16  output coefficient
- coef_valid_o  out  1  coef_o valid
- coef_ready_i  in  1  downstream accepts coefficient
- busy_o  out  1  high in any state except IDLE/LOAD

Behaviour:
- Reset: state = LOAD; all outputs 0, except pix_ready_o = 1 in the cycle after reset. Buffer and counters are cleared. Reset mid-operation abandons the row, and any late res_valid_i is ignored.
- States: LOAD → P_ISSUE → P_WAIT → (P_ISSUE | U_ISSUE) → U_WAIT → (U_ISSUE | OUT) → LOAD.
- LOAD:
  - pix_ready_o = 1; x[n] is written when pix_valid_i, n = 0..N-1.
  - After sample N-1 is accepted, the next cycle is P_ISSUE with lift_valid_o = 1.
- Flags per lane:
  - bit0 = lane valid (1)
  - bit1 = predict (1) / update (0)
  - bit2 = forward (1)
  - bits[9:3] = 0
  - So each lane is 7 in predict and 5 in update.
- Predict group g (g = 0..N/16-1), lane k: n = 2(8g+k)+1.
  - left = x[n-1], sam = x[n], right = x[n+1].
  - Boundary: n = N-1 uses right = x[N-2] (symmetric extension).
- Update group g, lane k: n = 2(8g+k).
  - left = x[n-1], sam = x[n], right = x[n+1]. Odd positions hold the predict results by this point.
  - Boundary: n = 0 uses left = x[1].
- ISSUE handshake:
  - lift_valid_o and all data/flag outputs are held stable until lift_valid_o && lift_ready_i.
  - Then the next state is WAIT, with lift_valid_o = 0.
  - Exactly one group is outstanding at any time.
- WAIT:
  - On res_valid_i, lane k result is written to x[n] for the same n as the issued lane.
  - If more groups remain in the pass: next cycle returns to ISSUE with g+1 and lift_valid_o = 1.
  - After the last predict group: U_ISSUE with g = 0. After the last update group: OUT.
  - res_valid_i outside WAIT is ignored.
- Simultaneous lift_ready_i and res_valid_i in an ISSUE cycle: res_valid_i is ignored; results are only accepted in WAIT.
- OUT:
  - Emits x[0], x[2], …, x[N-2], then x[1], x[3], …, x[N-1].
  - coef_valid_o / coef_o are held until coef_ready_i.
  - After the final handshake the block returns to LOAD next cycle.
- No arithmetic in this block; samples are moved bit-exact. Lifting math lives in jp_process.

Test Plan:
- Ramp row x[n] = n, N = 32, lift_ready_i = 1:
  - Predict group 0: left lanes = 0,2,…,14; sam = 1,3,…,15; right = 2,4,…,16.
  - flgs_s_o = each 10-bit field 7.
  - lift_valid_o asserts 1 cycle after the 32nd sample.
- Predict group 1, lane 7 (n = 31): right lane7 = 30 (boundary mirror); sam lane7 = 31.
- Bench returns res_i lanes = 1000+n for predict; check update group 0:
  - lane0 left = 1001 (mirror of x[1]), sam = 0, right = 1001.
  - lane1 left = 1001, right = 1003.
  - flags field = 5.
- Backpressure:
  - Hold lift_ready_i = 0 for 5 cycles: outputs stable, no state advance.
  - Pulse res_valid_i during ISSUE: ignored; results accepted only in WAIT.
- OUT ordering with coef_ready_i toggling 1/0:
  - The sequence is the 16 updated evens, then the 16 predict results 1001,1003,…,1031.
  - Then pix_ready_o = 1.
- Assert rst_i during U_WAIT:
  - Next cycle all outputs 0; pix_ready_o = 1 afterwards.
  - A fresh ramp row reproduces the scenario-1 values.
